div_sched: RTL
==============

Name: div_sched

Overview:
Sequencer for the shared iterative 32-bit divider used by the EXM stage for div.w/mod.w/div.wu/mod.wu.
- Accepts one request at a time from EXM over a valid/ready handshake.
- Runs a restoring shift-subtract datapath through a fixed state sequence and applies sign correction.
- Holds the result until EXM consumes it.
- Drives the EXM stall term (busy), and cancels cleanly on pipeline flush.

Parameters:
XLEN, 32, operand/result width
STEP_BITS, 1, quotient bits resolved per CALC cycle (legal: 1, 2); CALC lasts XLEN/STEP_BITS cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  divide request present
req_ready  out  1  block can accept (state IDLE)
req_signed  in  1  1 = signed operation
req_use_mod  in  1  1 = return remainder, 0 = quotient
req_x  in  XLEN  dividend
req_y  in  XLEN  divisor
flush  in  1  cancel any in-flight/held operation
resp_valid  out  1  result available
resp_ready  in  1  EXM consumes result
resp_result  out  XLEN  quotient or remainder
busy  out  1  req accepted and resp not yet consumed; EXM stalls on it

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, busy=0. Reset mid-operation aborts to IDLE.
- Accept on req_valid & req_ready & !flush. Latch signedness, use_mod, |x|, |y|, and the result signs:
  - quotient sign = x[31]^y[31]
  - remainder sign = x[31]
  - both signs only when req_signed.
- States and transitions:
  - IDLE->PREP on accept.
  - PREP (1 cycle): if y==0, go to FIX with q=all-ones and r=x; else load the partial remainder and go to CALC.
  - CALC (XLEN/STEP_BITS cycles, counter counts down to 0): each cycle shift in STEP_BITS dividend bits; subtract divisor if no borrow; set quotient bit(s). Counter==0 -> FIX.
  - FIX (1 cycle): negate q and/or r per the latched signs (not for y==0); select q or r by use_mod into resp_result. -> DONE.
  - DONE: resp_valid=1. resp_valid & resp_ready -> IDLE.
- Latency (STEP_BITS=1): accept at cycle 0, resp_valid at cycle 35. Divide-by-zero: resp_valid at cycle 3.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0. No special case; the abs/negate path produces it.
- Backpressure: in DONE with resp_ready=0, resp_result and resp_valid hold stable indefinitely.
- Flush:
  - Any state -> IDLE next cycle; resp_valid deasserts next cycle; no result is produced.
  - Flush in the same cycle as req_valid in IDLE means no accept.
  - Flush in the same cycle as a DONE handshake: handshake completes; flush has no further effect.
- busy = (state != IDLE) & !(state==DONE & resp_ready). Combinational from state and resp_ready.
- req_ready is combinational: state==IDLE.

Optional Feature:
DIV_RESULT_CACHE_EN
- With the macro defined:
  - On reaching FIX without flush, store {x, y, signed, q, r} and set cache_valid.
  - An accept whose x, y and signed all match cache_valid entries goes IDLE->DONE directly, with resp_result selected by the new use_mod. resp_valid arrives at cycle 1.
  - cache_valid clears on reset only; a flush mid-operation leaves the old entry intact.
- Without the macro: no cache storage; every request takes the full sequence.

Decomposition:
- Shared package/header (define.vh style): state encodings (IDLE, PREP, CALC, FIX, DONE), DIV_CNT_W=$clog2(XLEN/STEP_BITS+1), divide-by-zero quotient constant.
- Sub-module div_iter_step: combinational single-iteration shift-subtract of STEP_BITS bits, instantiated once inside CALC. FSM, counter, sign logic and optional cache stay in div_sched.

Test Plan:
- Unsigned 100 / 7, use_mod=0, resp_ready=1 -> resp_result=14 at cycle 35; repeat with use_mod=1 -> 2.
- Signed 0xFFFFFFF9 / 2 -> q=0xFFFFFFFD, with use_mod r=0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
- y=0, x=0x1234: use_mod=0 -> 0xFFFFFFFF; use_mod=1 -> 0x1234; resp_valid at cycle 3.
- Flush at cycle 10 of CALC -> next cycle state IDLE, req_ready=1, busy=0, resp_valid never asserted. A new request then completes correctly.
- resp_ready held 0 for 20 cycles after resp_valid -> resp_result stable, busy=1; raise resp_ready -> IDLE next cycle.
- Macro defined: 100/7 div, then 100/7 mod -> second resp_valid at cycle 1 with value 2. Macro undefined: cycle 35.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared definitions for the iterative divider sequencer: state encoding,
// counter width helper and the divide-by-zero quotient.
package div_sched_pkg;

  localparam int DIV_XLEN = 32;
  localparam logic [DIV_XLEN-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_t;

  function automatic int div_cnt_w(input int xlen, input int step_bits);
    return $clog2(xlen / step_bits + 1);
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// Request/response handshake between EXM (master) and the divider sequencer (slave).
interface div_sched_if #(parameter int XLEN = div_sched_pkg::DIV_XLEN);

  logic            req_valid;
  logic            req_ready;
  logic            req_signed;
  logic            req_use_mod;
  logic [XLEN-1:0] req_x;
  logic [XLEN-1:0] req_y;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  modport master (
    output req_valid, req_signed, req_use_mod, req_x, req_y, flush, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );

  modport slave (
    input  req_valid, req_signed, req_use_mod, req_x, req_y, flush, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );

endinterface

// File: rtl/div_iter_step.sv
// One CALC iteration of the restoring divider: shifts STEP_BITS dividend bits
// into the partial remainder, subtracting the divisor whenever it fits.
module div_iter_step #(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN-1:0] r;
  logic [XLEN-1:0] q;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  // r < dvs holds on entry to each bit, so trial < 2*dvs fits in XLEN+1 bits
  always_comb begin
    r     = rem_in;
    q     = quo_in;
    trial = '0;
    diff  = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      trial = {r, q[XLEN-1]};
      diff  = trial - {1'b0, dvs};
      q     = {q[XLEN-2:0], ~diff[XLEN]};
      r     = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    end
    rem_out = r;
    quo_out = q;
  end

endmodule

// File: rtl/div_sched.sv
// Sequencer for the shared iterative divider (div.w/mod.w/div.wu/mod.wu).
// Optional single-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
//
// state   | meaning
// IDLE    | ready for a request
// PREP    | load partial remainder, detect divide-by-zero
// CALC    | XLEN/STEP_BITS shift-subtract iterations
// FIX     | sign correction, select quotient or remainder
// DONE    | result held until EXM consumes it
module div_sched
  import div_sched_pkg::*;
#(
  parameter int XLEN      = DIV_XLEN,
  parameter int STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  div_sched_if.slave  bus
);

  localparam int DIV_CNT_W = div_cnt_w(XLEN, STEP_BITS);
  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(XLEN / STEP_BITS - 1);

  div_state_t state;
  div_state_t state_nx;

  logic [XLEN-1:0]      x_raw;
  logic [XLEN-1:0]      rem;
  logic [XLEN-1:0]      quo;
  logic [XLEN-1:0]      dvs;
  logic [XLEN-1:0]      result;
  logic [XLEN-1:0]      rem_step;
  logic [XLEN-1:0]      quo_step;
  logic [XLEN-1:0]      q_fix;
  logic [XLEN-1:0]      r_fix;
  logic [XLEN-1:0]      x_abs;
  logic [XLEN-1:0]      y_abs;
  logic [XLEN-1:0]      hit_result;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 use_mod;
  logic                 q_neg;
  logic                 r_neg;
  logic                 dbz;
  logic                 accept;
  logic                 hit;

  assign accept = bus.req_valid && (state == ST_IDLE) && !bus.flush;

  assign x_abs = (bus.req_signed && bus.req_x[XLEN-1]) ? -bus.req_x : bus.req_x;
  assign y_abs = (bus.req_signed && bus.req_y[XLEN-1]) ? -bus.req_y : bus.req_y;

  // The most negative dividend's magnitude is its own unsigned pattern, so the
  // 0x80000000 / -1 overflow case falls out of the abs/negate path unaided.
  assign q_fix = dbz ? XLEN'(DIV_ZERO_Q) : (q_neg ? -quo : quo);
  assign r_fix = dbz ? x_raw : (r_neg ? -rem : rem);

  div_iter_step #(
    .XLEN      (XLEN),
    .STEP_BITS (STEP_BITS)
  ) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvs     (dvs),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_valid;
  logic            c_signed;
  logic [XLEN-1:0] c_x;
  logic [XLEN-1:0] c_y;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_r;
  logic [XLEN-1:0] y_raw;
  logic            op_signed;

  assign hit = cache_valid && (c_x == bus.req_x) && (c_y == bus.req_y) &&
               (c_signed == bus.req_signed);
  assign hit_result = bus.req_use_mod ? c_r : c_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
    end else if (state == ST_FIX && !bus.flush) begin
      cache_valid <= 1'b1;
      c_x         <= x_raw;
      c_y         <= y_raw;
      c_signed    <= op_signed;
      c_q         <= q_fix;
      c_r         <= r_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      y_raw     <= bus.req_y;
      op_signed <= bus.req_signed;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_FIX && !bus.flush) begin
        result <= use_mod ? r_fix : q_fix;
      end else if (accept && hit) begin
        result <= hit_result;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = hit ? ST_DONE : ST_PREP;
      ST_PREP: state_nx = (dvs == '0) ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == '0) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: if (bus.resp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (bus.flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (accept) begin
          x_raw   <= bus.req_x;
          use_mod <= bus.req_use_mod;
          q_neg   <= bus.req_signed & (bus.req_x[XLEN-1] ^ bus.req_y[XLEN-1]);
          r_neg   <= bus.req_signed & bus.req_x[XLEN-1];
          quo     <= x_abs;
          dvs     <= y_abs;
        end
      end
      ST_PREP: begin
        rem <= '0;
        cnt <= CNT_LOAD;
        dbz <= (dvs == '0);
      end
      ST_CALC: begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt - DIV_CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.resp_valid  = (state == ST_DONE);
  assign bus.resp_result = result;
  assign bus.busy        = (state != ST_IDLE) && !((state == ST_DONE) && bus.resp_ready);

endmodule
